alu_seq_ctrl: RTL

//  Sequencer that fronts the 4-bit ALU with a valid/ready request/response interface.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_mul_step.sv | 14 +
 rtl/alu_seq_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, multiply iteration count and sequencer state encoding shared by the ALU front end.
package alu_pkg;
  localparam logic [3:0] OP_ADDC = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam int         MUL_ITERS = 4;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_e;
endpackage

// File: rtl/alu_mul_step.sv
// alu_mul_step: one shift-and-add multiply iteration; the add result comes from the external ALU.
module alu_mul_step (
  input  logic [3:0] p_i,
  input  logic [3:0] q_i,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  output logic [3:0] p_o,
  output logic [3:0] q_o
);
  logic [4:0] s;
  assign s   = q_i[0] ? {cout_i, sum_i} : {1'b0, p_i};
  assign p_o = s[4:1];
  assign q_o = {s[0], q_i[3:1]};
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: valid/ready sequencer for the 4-bit ALU; issues single ops once and runs
// MUL as shift-and-add iterations on the ALU add op.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter logic [3:0] MUL_OP  = OP_MUL,
  parameter int         MUL_ITR = MUL_ITERS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_op_i,
  input  logic [3:0] req_a_i,
  input  logic [3:0] req_b_i,
  input  logic       req_cin_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_cout_o,
  output logic       rsp_of_o,
  output logic       rsp_err_o,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [3:0] alu_op_o,
  output logic       alu_cin_o,
  input  logic [3:0] alu_out_i,
  input  logic       alu_cout_i,
  input  logic       alu_of_i
);
  state_e     state_q, state_d;
  logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d, p_q, p_d, q_q, q_d, p_nxt, q_nxt;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       cin_q, cin_d, cout_q, cout_d, of_q, of_d, err_q, err_d;
  logic       single, is_mul;

  alu_mul_step u_step (
    .p_i   (p_q),
    .q_i   (q_q),
    .sum_i (alu_out_i),
    .cout_i(alu_cout_i),
    .p_o   (p_nxt),
    .q_o   (q_nxt)
  );

  assign single      = (req_op_i >= OP_ADDC) && (req_op_i <= OP_LSR);
  assign is_mul      = req_op_i == MUL_OP;
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_data_o  = data_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_of_o    = of_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    cout_d    = cout_q;
    of_d      = of_q;
    err_d     = err_q;
    alu_a_o   = 4'h0;
    alu_b_o   = 4'h0;
    alu_op_o  = OP_NONE;
    alu_cin_o = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        op_d    = req_op_i;
        a_d     = req_a_i;
        b_d     = req_b_i;
        cin_d   = req_cin_i;
        p_d     = 4'h0;
        q_d     = req_b_i;
        cnt_d   = 3'd0;
        data_d  = 8'h00;
        cout_d  = 1'b0;
        of_d    = 1'b0;
        err_d   = !single && !is_mul;
        state_d = single ? EXEC : is_mul ? MUL : RESP;
      end
      EXEC: begin
        alu_a_o   = a_q;
        alu_b_o   = b_q;
        alu_op_o  = op_q;
        alu_cin_o = cin_q;
        data_d    = {4'h0, alu_out_i};
        cout_d    = alu_cout_i;
        of_d      = alu_of_i;
        state_d   = RESP;
      end
      MUL: begin
        alu_a_o  = p_q;
        alu_b_o  = a_q;
        alu_op_o = OP_ADD;
        p_d      = p_nxt;
        q_d      = q_nxt;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'(MUL_ITR - 1)) begin
          data_d  = {p_nxt, q_nxt};
          of_d    = |p_nxt;
          cout_d  = 1'b0;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      cin_q   <= 1'b0;
      p_q     <= 4'h0;
      q_q     <= 4'h0;
      cnt_q   <= 3'd0;
      data_q  <= 8'h00;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
      err_q   <= err_d;
    end
  end
endmodule
